// File: rtl/vga_pkg.sv
// Shared VGA constants, rectangle palette and the pixel/timing bundle
// carried through the draw pipeline.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;

  localparam logic [11:0] RECT_COLOR [8] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hF80, 12'h888
  };

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_pix_t;

endpackage

// File: rtl/rect_pos_ctl.sv
// Position register for one rectangle: moves by STEP on a frame tick while
// enabled, then clamps or wraps against the visible area.
module rect_pos_ctl
  import vga_pkg::*;
#(
  parameter int unsigned RESET_X   = 0,
  parameter int unsigned RESET_Y   = 0,
  parameter int unsigned RECT_W    = 48,
  parameter int unsigned RECT_H    = 64,
  parameter int unsigned STEP      = 4,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        enable_i,
  input  logic        up_i,
  input  logic        down_i,
  input  logic        left_i,
  input  logic        right_i,
  output logic [10:0] x_o,
  output logic [10:0] y_o
);

  localparam logic signed [11:0] XMAX   = 12'(H_ACTIVE - RECT_W);
  localparam logic signed [11:0] YMAX   = 12'(V_ACTIVE - RECT_H);
  localparam logic signed [11:0] STEP_S = 12'(STEP);

  logic [10:0]        x_q, x_d, y_q, y_d;
  logic signed [11:0] dx, dy, nx, ny;

  function automatic logic [10:0] limit(input logic signed [11:0] v,
                                        input logic signed [11:0] vmax);
    if (v < 12'sd0) begin
      return (EDGE_MODE == 1) ? vmax[10:0] : 11'd0;
    end else if (v > vmax) begin
      return (EDGE_MODE == 1) ? 11'd0 : vmax[10:0];
    end
    return v[10:0];
  endfunction

  always_comb begin
    dx = '0;
    dy = '0;
    if (right_i && !left_i) dx = STEP_S;
    else if (left_i && !right_i) dx = -STEP_S;
    if (down_i && !up_i) dy = STEP_S;
    else if (up_i && !down_i) dy = -STEP_S;
    nx  = $signed({1'b0, x_q}) + dx;
    ny  = $signed({1'b0, y_q}) + dy;
    x_d = x_q;
    y_d = y_q;
    if (tick_i && enable_i) begin
      x_d = limit(nx, XMAX);
      y_d = limit(ny, YMAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= 11'(RESET_X);
      y_q <= 11'(RESET_Y);
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/draw_rect_multi.sv
// Composites N_RECT button-movable rectangles over the background stream with
// a fixed 2-clock pixel latency; the selected rectangle gets a white outline.
module draw_rect_multi
  import vga_pkg::*;
#(
  parameter int unsigned N_RECT      = 4,
  parameter int unsigned RECT_W      = 48,
  parameter int unsigned RECT_H      = 64,
  parameter int unsigned STEP        = 4,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [((N_RECT > 1) ? $clog2(N_RECT) : 1)-1:0] sel,
  input  logic                                        move_up,
  input  logic                                        move_down,
  input  logic                                        move_left,
  input  logic                                        move_right,
  input  logic [10:0]                                 hcount_in,
  input  logic [10:0]                                 vcount_in,
  input  logic                                        hsync_in,
  input  logic                                        vsync_in,
  input  logic                                        hblnk_in,
  input  logic                                        vblnk_in,
  input  logic [11:0]                                 rgb_in,
  output logic [10:0]                                 hcount_out,
  output logic [10:0]                                 vcount_out,
  output logic                                        hsync_out,
  output logic                                        vsync_out,
  output logic                                        hblnk_out,
  output logic                                        vblnk_out,
  output logic [11:0]                                 rgb_out,
  output logic [10:0]                                 sel_x,
  output logic [10:0]                                 sel_y
);

  localparam int unsigned SelW = (N_RECT > 1) ? $clog2(N_RECT) : 1;
  localparam int unsigned SyncW = SelW + 4;

  if (N_RECT < 1 || N_RECT > 8 || SYNC_STAGES < 2 ||
      N_RECT * (RECT_W + 8) > H_ACTIVE) begin : gen_param_check
    $error("draw_rect_multi: illegal parameter combination");
  end

  logic [SyncW-1:0] sync_q [SYNC_STAGES];
  logic [SyncW-1:0] sync_d [SYNC_STAGES];
  logic [SelW-1:0]  sel_s;
  logic             up_s, down_s, left_s, right_s;
  logic             vblnk_prev_q, vblnk_prev_d, tick;

  logic [10:0]       rx [N_RECT];
  logic [10:0]       ry [N_RECT];

  vga_pix_t          pix_d1, pix_q1, pix_d2, pix_q2;
  logic [N_RECT-1:0] hit_d1, hit_q1;
  logic              ring_d1, ring_q1;
  logic [SelW-1:0]   sel_q1;
  logic [11:0]       h12, v12;
  logic              any_hit;
  logic [SelW-1:0]   win_idx;
  logic [11:0]       win_col;

  always_comb begin
    sync_d[0] = {sel, move_up, move_down, move_left, move_right};
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    {sel_s, up_s, down_s, left_s, right_s} = sync_q[SYNC_STAGES-1];
    vblnk_prev_d = vblnk_in;
    tick         = vblnk_in && !vblnk_prev_q;
  end

  for (genvar i = 0; i < N_RECT; i++) begin : gen_rect
    rect_pos_ctl #(
      .RESET_X  (i * (RECT_W + 8)),
      .RESET_Y  (0),
      .RECT_W   (RECT_W),
      .RECT_H   (RECT_H),
      .STEP     (STEP),
      .EDGE_MODE(EDGE_MODE)
    ) u_pos (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick),
      .enable_i(sel_s == SelW'(i)),
      .up_i    (up_s),
      .down_i  (down_s),
      .left_i  (left_s),
      .right_i (right_s),
      .x_o     (rx[i]),
      .y_o     (ry[i])
    );
  end

  // Stage 1: hit test against every rectangle, outline test for the selected one.
  always_comb begin
    pix_d1  = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in, vsync: vsync_in,
                hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
    h12     = {1'b0, hcount_in};
    v12     = {1'b0, vcount_in};
    hit_d1  = '0;
    ring_d1 = 1'b0;
    sel_x   = '0;
    sel_y   = '0;
    for (int i = 0; i < N_RECT; i++) begin
      hit_d1[i] = (h12 >= {1'b0, rx[i]}) && (h12 < {1'b0, rx[i]} + 12'(RECT_W)) &&
                  (v12 >= {1'b0, ry[i]}) && (v12 < {1'b0, ry[i]} + 12'(RECT_H));
      // Only indices below N_RECT can match, so an out-of-range sel reads 0.
      if (sel_s == SelW'(i)) begin
        sel_x   = rx[i];
        sel_y   = ry[i];
        ring_d1 = hit_d1[i] &&
                  ((h12 == {1'b0, rx[i]}) || (h12 == {1'b0, rx[i]} + 12'(RECT_W - 1)) ||
                   (v12 == {1'b0, ry[i]}) || (v12 == {1'b0, ry[i]} + 12'(RECT_H - 1)));
      end
    end
  end

  // Stage 2: lowest-index hit wins.
  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    win_col = '0;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (hit_q1[i]) begin
        any_hit = 1'b1;
        win_idx = SelW'(i);
        win_col = RECT_COLOR[3'(i % 8)];
      end
    end
    pix_d2 = pix_q1;
    if (!(pix_q1.hblnk || pix_q1.vblnk) && any_hit) begin
      pix_d2.rgb = (ring_q1 && (win_idx == sel_q1)) ? 12'hFFF : win_col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      vblnk_prev_q <= 1'b0;
      pix_q1       <= '0;
      hit_q1       <= '0;
      ring_q1      <= 1'b0;
      sel_q1       <= '0;
      pix_q2       <= '0;
    end else begin
      sync_q       <= sync_d;
      vblnk_prev_q <= vblnk_prev_d;
      pix_q1       <= pix_d1;
      hit_q1       <= hit_d1;
      ring_q1      <= ring_d1;
      sel_q1       <= sel_s;
      pix_q2       <= pix_d2;
    end
  end

  assign hcount_out = pix_q2.hcount;
  assign vcount_out = pix_q2.vcount;
  assign hsync_out  = pix_q2.hsync;
  assign vsync_out  = pix_q2.vsync;
  assign hblnk_out  = pix_q2.hblnk;
  assign vblnk_out  = pix_q2.vblnk;
  assign rgb_out    = pix_q2.rgb;

endmodule

// File: tb/tb_draw_rect_multi.sv
// Scoreboard bench: a clamp instance (4 rects) and a wrap instance (3 rects)
// share stimulus and are compared against a behavioural rectangle model.
module tb_draw_rect_multi;

  localparam int RW   = 48;
  localparam int RH   = 64;
  localparam int STP  = 4;
  localparam int XMAX = 800 - RW;
  localparam int YMAX = 600 - RH;
  localparam int NR [2] = '{4, 3};
  localparam int EM [2] = '{0, 1};
  localparam logic [11:0] PAL [8] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hF80, 12'h888
  };

  typedef struct {
    int          cyc;
    logic [11:0] rgb_c, rgb_w;
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  sel = '0;
  logic        mu = 1'b0, md = 1'b0, ml = 1'b0, mr = 1'b0;
  logic [10:0] hc_in = '0, vc_in = '0;
  logic        hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
  logic [11:0] rgb_in = '0;

  logic [10:0] hc_c, vc_c, sx_c, sy_c, hc_w, vc_w, sx_w, sy_w;
  logic        hs_c, vs_c, hb_c, vb_c, hs_w, vs_w, hb_w, vb_w;
  logic [11:0] rgb_c, rgb_w;

  draw_rect_multi dut_c (
    .clk(clk), .rst(rst), .sel(sel), .move_up(mu), .move_down(md), .move_left(ml),
    .move_right(mr), .hcount_in(hc_in), .vcount_in(vc_in), .hsync_in(hs_in),
    .vsync_in(vs_in), .hblnk_in(hb_in), .vblnk_in(vb_in), .rgb_in(rgb_in),
    .hcount_out(hc_c), .vcount_out(vc_c), .hsync_out(hs_c), .vsync_out(vs_c),
    .hblnk_out(hb_c), .vblnk_out(vb_c), .rgb_out(rgb_c), .sel_x(sx_c), .sel_y(sy_c)
  );

  draw_rect_multi #(.N_RECT(3), .EDGE_MODE(1)) dut_w (
    .clk(clk), .rst(rst), .sel(sel), .move_up(mu), .move_down(md), .move_left(ml),
    .move_right(mr), .hcount_in(hc_in), .vcount_in(vc_in), .hsync_in(hs_in),
    .vsync_in(vs_in), .hblnk_in(hb_in), .vblnk_in(vb_in), .rgb_in(rgb_in),
    .hcount_out(hc_w), .vcount_out(vc_w), .hsync_out(hs_w), .vsync_out(vs_w),
    .hblnk_out(hb_w), .vblnk_out(vb_w), .rgb_out(rgb_w), .sel_x(sx_w), .sel_y(sy_w)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, cur_cyc = 0;
  bit   in_rst = 1'b1;
  int   mx [2][8], my [2][8];
  int   exp_sx [2], exp_sy [2];
  logic [5:0] sq [$];
  bit   vprev = 1'b0;
  int   fpos = 0, flen = 8;
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cur_cyc, act, req);
    end
  endtask

  function automatic void reset_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        mx[k][i] = i * (RW + 8);
        my[k][i] = 0;
      end
  endfunction

  function automatic int lim(input int v, input int vmax, input int mode);
    if (v < 0) return (mode == 1) ? vmax : 0;
    if (v > vmax) return (mode == 1) ? 0 : vmax;
    return v;
  endfunction

  // b = {up, down, left, right}
  function automatic void move(input int s, input logic [3:0] b);
    int dx, dy;
    dx = (b[0] && !b[1]) ? STP : ((b[1] && !b[0]) ? -STP : 0);
    dy = (b[2] && !b[3]) ? STP : ((b[3] && !b[2]) ? -STP : 0);
    for (int k = 0; k < 2; k++)
      if (s < NR[k]) begin
        mx[k][s] = lim(mx[k][s] + dx, XMAX, EM[k]);
        my[k][s] = lim(my[k][s] + dy, YMAX, EM[k]);
      end
  endfunction

  function automatic logic [11:0] ref_pix(input int k, input int h, input int v, input int s,
                                          input bit blank, input logic [11:0] bg);
    int w;
    w = -1;
    if (blank) return bg;
    for (int i = 0; i < NR[k]; i++)
      if (w < 0 && h >= mx[k][i] && h < mx[k][i] + RW && v >= my[k][i] && v < my[k][i] + RH)
        w = i;
    if (w < 0) return bg;
    if (w == s && (h == mx[k][w] || h == mx[k][w] + RW - 1 ||
                   v == my[k][w] || v == my[k][w] + RH - 1))
      return 12'hFFF;
    return PAL[w % 8];
  endfunction

  function automatic int near(input int base, input int size);
    case ($urandom_range(0, 6))
      0: return base - 1;
      1: return base;
      2: return base + 1;
      3: return base + size - 2;
      4: return base + size - 1;
      5: return base + size;
      default: return base + int'($urandom_range(0, size - 1));
    endcase
  endfunction

  task automatic step(input bit r, input logic [1:0] s, input logic [3:0] b, input bit force_pix);
    int h, v, k, i, ss;
    bit hb, vb, tick;
    logic [11:0] bg;
    logic [5:0] sy;
    exp_t e;
    @(posedge clk);
    #1;
    cur_cyc = cyc;
    if (fpos >= flen) begin
      fpos = 0;
      flen = $urandom_range(6, 10);
    end
    vb = (fpos >= flen - 2);
    fpos++;
    hb = ($urandom_range(0, 7) == 0);
    if (force_pix) begin
      h = 60; v = 10; hb = 1'b0; vb = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, 1);
      i = $urandom_range(0, NR[k] - 1);
      h = near(mx[k][i], RW);
      v = near(my[k][i], RH);
      if (h < 0) h = 0;
      if (v < 0) v = 0;
    end else begin
      h = $urandom_range(0, 850);
      v = $urandom_range(0, 650);
    end
    bg = 12'($urandom_range(0, 4095));
    rst = r; sel = s; {mu, md, ml, mr} = b;
    hc_in = 11'(h); vc_in = 11'(v); hb_in = hb; vb_in = vb; rgb_in = bg;
    hs_in = 1'($urandom_range(0, 1)); vs_in = 1'($urandom_range(0, 1));
    in_rst = r;
    if (r) begin
      reset_model();
      sb.delete();
      sq = '{6'd0, 6'd0};
      vprev = 1'b0;
      exp_sx = '{0, 0};
      exp_sy = '{0, 0};
    end else begin
      sy = sq.pop_front();
      sq.push_back({s, b});
      ss = int'(sy[5:4]);
      for (int kk = 0; kk < 2; kk++) begin
        exp_sx[kk] = (ss < NR[kk]) ? mx[kk][ss] : 0;
        exp_sy[kk] = (ss < NR[kk]) ? my[kk][ss] : 0;
      end
      e.cyc = cur_cyc;
      e.rgb_c = ref_pix(0, h, v, ss, hb | vb, bg);
      e.rgb_w = ref_pix(1, h, v, ss, hb | vb, bg);
      e.hc = 11'(h); e.vc = 11'(v); e.hs = hs_in; e.vs = vs_in; e.hb = hb; e.vb = vb;
      sb.push_back(e);
      tick = vb && !vprev;
      if (tick) move(ss, sy[3:0]);
      vprev = vb;
    end
    cyc++;
  endtask

  task automatic run(input logic [1:0] s, input logic [3:0] b, input int n);
    repeat (n) step(1'b0, s, b, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        chk("rst_rgb_c", 32'(rgb_c), 0);
        chk("rst_rgb_w", 32'(rgb_w), 0);
        chk("rst_cnt_c", 32'({hc_c, vc_c, hs_c, vs_c, hb_c, vb_c}), 0);
        chk("rst_sel_c", 32'({sx_c, sy_c}), 0);
        chk("rst_sel_w", 32'({sx_w, sy_w}), 0);
      end else begin
        chk("sel_x_c", 32'(sx_c), 32'(exp_sx[0]));
        chk("sel_y_c", 32'(sy_c), 32'(exp_sy[0]));
        chk("sel_x_w", 32'(sx_w), 32'(exp_sx[1]));
        chk("sel_y_w", 32'(sy_w), 32'(exp_sy[1]));
        if (sb.size() > 0 && sb[0].cyc == cur_cyc - 2) begin
          e = sb.pop_front();
          chk("rgb_c", 32'(rgb_c), 32'(e.rgb_c));
          chk("rgb_w", 32'(rgb_w), 32'(e.rgb_w));
          chk("hcount_c", 32'(hc_c), 32'(e.hc));
          chk("vcount_c", 32'(vc_c), 32'(e.vc));
          chk("timing_c", 32'({hs_c, vs_c, hb_c, vb_c}), 32'({e.hs, e.vs, e.hb, e.vb}));
          chk("pix_w", 32'({hc_w, vc_w, hs_w, vs_w, hb_w, vb_w}),
              32'({e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}));
        end
      end
    end
  end

  initial begin : stimulus
    reset_model();
    sq = '{6'd0, 6'd0};
    exp_sx = '{0, 0};
    exp_sy = '{0, 0};
    repeat (3) step(1'b1, 2'd0, 4'b0000, 1'b0);
    step(1'b0, 2'd0, 4'b0000, 1'b1);
    run(2'd1, 4'b0001, 30);
    run(2'd1, 4'b0000, 30);
    run(2'd0, 4'b1010, 60);
    run(2'd0, 4'b0100, 1800);
    run(2'd1, 4'b0010, 40);
    run(2'd0, 4'b0011, 40);
    run(2'd0, 4'b0010, 20);
    run(2'd0, 4'b0001, 20);
    run(2'd2, 4'b0001, 40);
    run(2'd3, 4'b1010, 40);
    repeat (3) step(1'b1, 2'd1, 4'b0001, 1'b0);
    step(1'b0, 2'd0, 4'b0000, 1'b1);
    for (int j = 0; j < 40; j++)
      run(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(16, 96));
    repeat (4) step(1'b0, 2'd0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
